// File: rtl/ped_signal_ctrl_pkg.sv
// Shared types and lamp codes for the pedestrian signal controller.
package ped_signal_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        WALK,
        FLASH
    } ped_state_e;

    localparam logic [2:0] VEH_RED = 3'b110;
    localparam logic [2:0] VEH_YEL = 3'b101;
    localparam logic [2:0] VEH_GRN = 3'b011;

    localparam logic [1:0] PED_STOP = 2'b10;
    localparam logic [1:0] PED_WALK = 2'b01;
    localparam logic [1:0] PED_DARK = 2'b11;

    function automatic logic veh_legal(input logic [2:0] code);
        return (code == VEH_RED) || (code == VEH_YEL) || (code == VEH_GRN);
    endfunction

endpackage

// File: rtl/ped_signal_ctrl_if.sv
// Vehicle lamp input and pedestrian lamp/status outputs.
interface ped_signal_ctrl_if;
    import ped_signal_ctrl_pkg::*;

    logic [2:0] veh_led;
    logic [1:0] ped_led;
    logic [3:0] sec_left;
    logic       walk_active;
    logic       fault;

    modport master (
        output veh_led,
        input  ped_led,
        input  sec_left,
        input  walk_active,
        input  fault
    );

    modport slave (
        input  veh_led,
        output ped_led,
        output sec_left,
        output walk_active,
        output fault
    );

endinterface

// File: rtl/ped_signal_ctrl_tick_gen.sv
// Free-running divider: one-cycle pulse every N cycles after a clear.
module tick_gen #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(N - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q + 32'd1;
        if (clr || count_q == LAST) begin
            count_d = '0;
        end
    end

    assign tick = !clr && (count_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian lamp controller: grants guarded, timed walk phases
// only while vehicles hold red; aborts on leaving red or bad codes.
module ped_signal_ctrl
    import ped_signal_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned GUARD_CYC = 12_500_000,
    parameter int unsigned WALK_SEC  = 2,
    parameter int unsigned FLASH_SEC = 1,
    parameter int unsigned BLINK_CYC = 12_500_000
) (
    input  logic              clk,
    input  logic              rst,
    ped_signal_ctrl_if.slave  bus
);

    localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYC - 1);
    localparam logic [3:0]  SEC_TOTAL  = 4'(WALK_SEC + FLASH_SEC);
    localparam logic [3:0]  SEC_FLASH  = 4'(FLASH_SEC + 1);

    ped_state_e  state_q, state_d;
    logic [2:0]  veh_prev_q, veh_prev_d;
    logic [31:0] cyc_q, cyc_d;
    logic [3:0]  sec_left_q, sec_left_d;
    logic [1:0]  ped_led_q, ped_led_d;
    logic        walk_active_q, walk_active_d;
    logic        fault_q, fault_d;

    logic        sec_tick;
    logic        blink_tick;
    logic        sec_clr;
    logic        blink_clr;
    logic        is_red;
    logic        legal;
    logic        red_entry;
    logic        abort;
    logic [3:0]  sec_dec;

    assign sec_clr   = !(state_q == WALK || state_q == FLASH);
    assign blink_clr = (state_q != FLASH);

    tick_gen #(.N(CLK_HZ)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (sec_clr),
        .tick (sec_tick)
    );

    tick_gen #(.N(BLINK_CYC)) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (blink_clr),
        .tick (blink_tick)
    );

    assign is_red    = (bus.veh_led == VEH_RED);
    assign legal     = veh_legal(bus.veh_led);
    assign red_entry = is_red && (veh_prev_q != VEH_RED);
    assign abort     = (state_q != IDLE) && !is_red;
    assign sec_dec   = (sec_left_q == 4'd0) ? 4'd0 : sec_left_q - 4'd1;

    always_comb begin
        state_d       = state_q;
        veh_prev_d    = bus.veh_led;
        cyc_d         = cyc_q;
        sec_left_d    = sec_left_q;
        ped_led_d     = ped_led_q;
        walk_active_d = walk_active_q;
        fault_d       = fault_q;

        // Bad codes and leaving red both beat any timer event.
        if (!legal || abort) begin
            fault_d       = fault_q | !legal;
            state_d       = IDLE;
            cyc_d         = '0;
            sec_left_d    = '0;
            ped_led_d     = PED_STOP;
            walk_active_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ped_led_d = PED_STOP;
                    if (red_entry && !fault_q) begin
                        state_d = GUARD;
                        cyc_d   = '0;
                    end
                end
                GUARD: begin
                    if (cyc_q == GUARD_LAST) begin
                        state_d       = WALK;
                        sec_left_d    = SEC_TOTAL;
                        ped_led_d     = PED_WALK;
                        walk_active_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + 32'd1;
                    end
                end
                WALK: begin
                    if (sec_tick) begin
                        sec_left_d = sec_dec;
                        if (sec_left_q == SEC_FLASH) begin
                            state_d = FLASH;
                        end
                    end
                end
                FLASH: begin
                    if (sec_tick && sec_left_q <= 4'd1) begin
                        state_d       = IDLE;
                        sec_left_d    = '0;
                        ped_led_d     = PED_STOP;
                        walk_active_d = 1'b0;
                    end else begin
                        if (sec_tick) begin
                            sec_left_d = sec_dec;
                        end
                        if (blink_tick) begin
                            ped_led_d = ped_led_q ^ (PED_WALK ^ PED_DARK);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            veh_prev_q    <= VEH_RED;
            cyc_q         <= '0;
            sec_left_q    <= '0;
            ped_led_q     <= PED_STOP;
            walk_active_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            veh_prev_q    <= veh_prev_d;
            cyc_q         <= cyc_d;
            sec_left_q    <= sec_left_d;
            ped_led_q     <= ped_led_d;
            walk_active_q <= walk_active_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.ped_led     = ped_led_q;
    assign bus.sec_left    = sec_left_q;
    assign bus.walk_active = walk_active_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with small timing parameters.
module tb_ped_signal_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic any_walk;

    ped_signal_ctrl_if bus ();

    ped_signal_ctrl #(
        .CLK_HZ    (10),
        .GUARD_CYC (3),
        .WALK_SEC  (2),
        .FLASH_SEC (1),
        .BLINK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Green, yellow, then red: the sample after the red edge is GUARD #0.
    task automatic go_red();
        bus.veh_led = 3'b011;
        step(1);
        bus.veh_led = 3'b101;
        step(1);
        bus.veh_led = 3'b110;
        step(1);
    endtask

    initial begin
        bus.veh_led = 3'b110;
        #12;
        chk("rst_ped", 8'(bus.ped_led), 8'b10);
        chk("rst_sec", 8'(bus.sec_left), 8'd0);
        chk("rst_walk", 8'(bus.walk_active), 8'd0);
        chk("rst_fault", 8'(bus.fault), 8'd0);
        rst = 1'b1;

        any_walk = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            any_walk = any_walk | bus.walk_active | (bus.ped_led != 2'b10);
        end
        chk("t1_no_walk", 8'(any_walk), 8'd0);

        go_red();
        for (int i = 0; i < 3; i++) begin
            chk("t2_guard_ped", 8'(bus.ped_led), 8'b10);
            chk("t2_guard_walk", 8'(bus.walk_active), 8'd0);
            step(1);
        end
        for (int i = 0; i < 20; i++) begin
            chk("t2_walk_ped", 8'(bus.ped_led), 8'b01);
            chk("t2_walk_sec", 8'(bus.sec_left), (i < 10) ? 8'd3 : 8'd2);
            chk("t2_walk_act", 8'(bus.walk_active), 8'd1);
            step(1);
        end
        for (int i = 0; i < 10; i++) begin
            chk("t2_flash_ped", 8'(bus.ped_led),
                (((i / 2) % 2) == 1) ? 8'b11 : 8'b01);
            chk("t2_flash_sec", 8'(bus.sec_left), 8'd1);
            step(1);
        end
        chk("t2_end_ped", 8'(bus.ped_led), 8'b10);
        chk("t2_end_sec", 8'(bus.sec_left), 8'd0);
        chk("t2_end_walk", 8'(bus.walk_active), 8'd0);
        step(17);
        chk("t2_hold_ped", 8'(bus.ped_led), 8'b10);

        go_red();
        step(3);
        step(3);
        chk("t3_in_walk", 8'(bus.ped_led), 8'b01);
        bus.veh_led = 3'b011;
        step(1);
        chk("t3_abort_ped", 8'(bus.ped_led), 8'b10);
        chk("t3_abort_sec", 8'(bus.sec_left), 8'd0);
        chk("t3_abort_walk", 8'(bus.walk_active), 8'd0);

        go_red();
        step(3);
        step(19);
        chk("t5_pre_sec", 8'(bus.sec_left), 8'd2);
        chk("t5_pre_ped", 8'(bus.ped_led), 8'b01);
        bus.veh_led = 3'b011;
        step(1);
        chk("t5_abort_ped", 8'(bus.ped_led), 8'b10);
        chk("t5_abort_walk", 8'(bus.walk_active), 8'd0);
        chk("t5_abort_sec", 8'(bus.sec_left), 8'd0);
        step(3);
        chk("t5_stay_ped", 8'(bus.ped_led), 8'b10);

        go_red();
        step(3 + 20 + 3);
        chk("t6_in_flash", 8'(bus.ped_led), 8'b11);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_ped", 8'(bus.ped_led), 8'b10);
        chk("t6_rst_sec", 8'(bus.sec_left), 8'd0);
        chk("t6_rst_walk", 8'(bus.walk_active), 8'd0);
        #3;
        rst = 1'b1;
        step(5);
        chk("t6_post_ped", 8'(bus.ped_led), 8'b10);

        bus.veh_led = 3'b111;
        step(1);
        chk("t4_fault_set", 8'(bus.fault), 8'd1);
        chk("t4_fault_ped", 8'(bus.ped_led), 8'b10);
        any_walk = 1'b0;
        bus.veh_led = 3'b011;
        step(1);
        bus.veh_led = 3'b110;
        for (int i = 0; i < 25; i++) begin
            step(1);
            any_walk = any_walk | bus.walk_active | (bus.ped_led != 2'b10);
        end
        chk("t4_no_walk", 8'(any_walk), 8'd0);
        chk("t4_fault_sticky", 8'(bus.fault), 8'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t4_fault_clr", 8'(bus.fault), 8'd0);
        #3;
        rst = 1'b1;
        go_red();
        step(3);
        chk("t4_walk_again", 8'(bus.ped_led), 8'b01);
        chk("t4_sec_again", 8'(bus.sec_left), 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Downstream stage of the vehicle traffic-light sequencer.
- Watches the registered 3-bit vehicle lamp code and drives the pedestrian lamp pair: don't-walk (red) and walk (green).
- Grants a walk phase only while vehicles see red. Runs guard, walk, flashing-walk, and countdown timing.
- Forces don't-walk immediately if the vehicle code leaves red or becomes illegal.

Parameters:
- CLK_HZ, 50_000_000: clock cycles per second; period of the seconds tick.
- GUARD_CYC, 12_500_000: all-red guard cycles between vehicle-red entry and walk.
- WALK_SEC, 2: steady walk duration, in seconds.
- FLASH_SEC, 1: flashing walk duration, in seconds.
- BLINK_CYC, 12_500_000: cycles per half-period of the walk flash.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- veh_led, input, 3: vehicle lamp code, active-low. 3'b110 = red, 3'b101 = yellow, 3'b011 = green.
- ped_led, output, 2: pedestrian lamps, active-low. bit0 = don't-walk, bit1 = walk.
- sec_left, output, 4: remaining walk+flash seconds; 0 when not walking.
- walk_active, output, 1: high in WALK and FLASH.
- fault, output, 1: sticky illegal-vehicle-code flag.

Behaviour:
Reset (rst low, asynchronous):
- state = IDLE, ped_led = 2'b10, sec_left = 0, walk_active = 0, fault = 0.
- veh_prev = 3'b110, so no walk is granted for the red present at reset.
- All outputs are registered.

Red-entry edge:
- red_entry = (veh_led == 3'b110) && (veh_prev != 3'b110).
- veh_prev <= veh_led every cycle.
- A repeated red code without a change is not an entry.

State machine:
- IDLE: ped_led = 2'b10. On red_entry go to GUARD and clear the cycle counter.
- GUARD: ped_led = 2'b10. After exactly GUARD_CYC cycles in GUARD, go to WALK. On that transition load sec_left = WALK_SEC + FLASH_SEC and clear the second prescaler.
- WALK: ped_led = 2'b01, walk_active = 1. sec_left decrements on each seconds tick (every CLK_HZ cycles). After WALK_SEC ticks, go to FLASH with the walk lamp lit in the first phase.
- FLASH: ped_led alternates 2'b01 / 2'b11 every BLINK_CYC cycles; don't-walk stays off. sec_left continues decrementing. After FLASH_SEC ticks (sec_left reaches 0), go to IDLE with ped_led = 2'b10.

Abort (GUARD, WALK or FLASH):
- If veh_led != 3'b110, go to IDLE next cycle: ped_led = 2'b10, sec_left = 0, walk_active = 0.
- Abort has priority over any simultaneous timer expiry or tick.

Fault:
- If veh_led is not one of {110, 101, 011}, set fault = 1 and force IDLE, in any state.
- fault is cleared only by reset.
- While fault = 1, red_entry is ignored and ped_led is held at 2'b10.

Widths and sizing:
- Cycle and prescaler counters are 32 bits.
- sec_left saturates at 0 and never wraps.
- WALK_SEC + FLASH_SEC must be ≤ 15.
- Integration constraint: GUARD_CYC + (WALK_SEC + FLASH_SEC) × CLK_HZ must be shorter than the upstream red dwell (170_000_000 cycles). Otherwise the abort path truncates every walk phase.

Latency:
- ped_led reflects a state change on the clock edge after the deciding condition.
- Abort to don't-walk takes 1 cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GUARD, WALK, FLASH);
  - vehicle lamp code constants VEH_RED = 3'b110, VEH_YEL = 3'b101, VEH_GRN = 3'b011;
  - pedestrian code constants PED_STOP = 2'b10, PED_WALK = 2'b01, PED_DARK = 2'b11.
- One sub-module, tick_gen:
  - parameter N; synchronous clear input;
  - one-cycle pulse every N cycles;
  - instantiated for the seconds tick and the blink tick.

Test Plan (all scenarios use CLK_HZ=10, GUARD_CYC=3, WALK_SEC=2, FLASH_SEC=1, BLINK_CYC=2):
- Reset with veh_led = 110 held for 100 cycles → ped_led stays 10, walk_active = 0, no walk granted.
- Sequence 011 → 101 → 110, then hold 110 for 50 cycles:
  - GUARD lasts 3 cycles;
  - ped_led = 01 for 20 cycles, sec_left 3 → 2 → 1;
  - FLASH 10 cycles with pattern 01,01,11,11,…;
  - then ped_led = 10, sec_left = 0.
- veh_led changes 110 → 011 on the 5th WALK cycle → next cycle ped_led = 10, sec_left = 0, walk_active = 0.
- veh_led = 111 for one cycle during IDLE → fault = 1 and stays 1; a later 011 → 110 entry grants no walk until rst pulses low.
- veh_led leaves red in the same cycle the WALK → FLASH tick fires → state is IDLE (abort wins); FLASH never entered.
- rst asserted low mid-FLASH → ped_led = 10, sec_left = 0 immediately (asynchronous), before the next clock edge.
